// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: four-pass address / inverted-address march over every
// location of a DEPTH x WIDTH memory, reporting pass/fail and the first mismatch.
module mem_bist_ctrl #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(2*DEPTH)+1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [WIDTH-1:0]  fail_exp,
    output logic [WIDTH-1:0]  fail_got,
    output logic              fail_pass,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  data_in,
    input  logic [WIDTH-1:0]  data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR1, S_RQ1, S_CK1, S_WR2, S_RQ2, S_CK2, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] k, k_nxt;
    logic              busy_nxt, done_nxt, pass_nxt, read_nxt, write_nxt;
    logic              fail_pass_nxt;
    logic [CNT_W-1:0]  err_nxt;
    logic [ADDR_W-1:0] fail_addr_nxt, addr_nxt;
    logic [WIDTH-1:0]  fail_exp_nxt, fail_got_nxt, data_in_nxt;
    logic              chk_en, last;
    logic [WIDTH-1:0]  exp_val;

    // Address zero-extended or truncated to the data width.
    function automatic logic [WIDTH-1:0] pat(input logic [ADDR_W-1:0] a);
        logic [WIDTH+ADDR_W-1:0] wide;
        wide = {{WIDTH{1'b0}}, a};
        return wide[WIDTH-1:0];
    endfunction

    assign last = &k;

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        read_nxt      = 1'b0;
        write_nxt     = 1'b0;
        addr_nxt      = '0;
        data_in_nxt   = '0;
        pass_nxt      = pass;
        err_nxt       = err_count;
        fail_addr_nxt = fail_addr;
        fail_exp_nxt  = fail_exp;
        fail_got_nxt  = fail_got;
        fail_pass_nxt = fail_pass;
        chk_en        = 1'b0;
        exp_val       = pat(k);

        case (state)
            S_IDLE: if (start) begin
                state_nxt     = S_WR1;
                k_nxt         = '0;
                err_nxt       = '0;
                fail_addr_nxt = '0;
                fail_exp_nxt  = '0;
                fail_got_nxt  = '0;
                fail_pass_nxt = 1'b0;
                pass_nxt      = 1'b0;
            end
            S_WR1, S_WR2: begin
                k_nxt = last ? '0 : k + ADDR_W'(1);
                if (last) state_nxt = (state == S_WR1) ? S_RQ1 : S_RQ2;
            end
            S_RQ1: state_nxt = S_CK1;
            S_RQ2: state_nxt = S_CK2;
            S_CK1, S_CK2: begin
                chk_en = 1'b1;
                if (state == S_CK2) exp_val = ~pat(k);
                k_nxt = last ? '0 : k + ADDR_W'(1);
                if (state == S_CK1) state_nxt = last ? S_WR2 : S_RQ1;
                else                state_nxt = last ? S_DONE : S_RQ2;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Only the first mismatch of a run is recorded in detail.
        if (chk_en && (data_out != exp_val)) begin
            err_nxt = err_count + CNT_W'(1);
            if (err_count == '0) begin
                fail_addr_nxt = k;
                fail_exp_nxt  = exp_val;
                fail_got_nxt  = data_out;
                fail_pass_nxt = (state == S_CK2);
            end
        end

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_nxt)
            S_WR1, S_WR2: begin
                busy_nxt    = 1'b1;
                write_nxt   = 1'b1;
                addr_nxt    = k_nxt;
                data_in_nxt = (state_nxt == S_WR1) ? pat(k_nxt) : ~pat(k_nxt);
            end
            S_RQ1, S_RQ2: begin
                busy_nxt = 1'b1;
                read_nxt = 1'b1;
                addr_nxt = k_nxt;
            end
            S_CK1, S_CK2: begin
                busy_nxt = 1'b1;
                addr_nxt = k_nxt;
            end
            S_DONE: begin
                done_nxt = 1'b1;
                pass_nxt = (err_nxt == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            fail_pass <= 1'b0;
            read      <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            data_in   <= '0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_nxt;
            fail_addr <= fail_addr_nxt;
            fail_exp  <= fail_exp_nxt;
            fail_got  <= fail_got_nxt;
            fail_pass <= fail_pass_nxt;
            read      <= read_nxt;
            write     <= write_nxt;
            addr      <= addr_nxt;
            data_in   <= data_in_nxt;
        end
    end

endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Built-in self-test controller that sits directly upstream of the `mem` block and drives its `read`/`write`/`addr`/`data_in` pins in place of the directed test program. On `start` it runs a fixed four-pass pattern over every location: write address pattern, read/check, write inverted pattern, read/check. It then reports pass/fail, an error count and the first failing location. It is parameterised on the same DEPTH/WIDTH pair as the memory and its interface.

## Interface
- DEPTH, 32, number of memory locations (power of two, ≥ 2)
- WIDTH, 8, data width in bits (≥ 1)
- ADDR_W, $clog2(DEPTH), address width (5 at defaults)
- CNT_W, $clog2(2*DEPTH)+1, error counter width (7 at defaults)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE
- busy  out  1  high while the test runs
- done  out  1  one-cycle pulse at test end
- pass  out  1  1 when the last run had zero errors; valid from done, held until next start
- err_count  out  CNT_W  mismatches in the current or last run
- fail_addr  out  ADDR_W  address of the first mismatch
- fail_exp  out  WIDTH  expected data at the first mismatch
- fail_got  out  WIDTH  observed data at the first mismatch
- fail_pass  out  1  0 = first mismatch in check pass 1, 1 = pass 2
- read  out  1  memory read strobe
- write  out  1  memory write strobe
- addr  out  ADDR_W  memory address
- data_in  out  WIDTH  data to memory
- data_out  in  WIDTH  data from memory

## Operation
- Memory contract: `mem` samples read/write/addr/data_in at posedge. After a read, data_out is valid at the next posedge.
- Pattern P(a) is the address zero-extended or truncated to WIDTH bits; ~P(a) is its bitwise inverse. At defaults, P(a) = 0x00..0x1F and ~P(a) = 0xFF..0xE0.
- States:
  - IDLE: strobes low, addr=0, data_in=0. If start=1, clear err_count and the fail_* outputs, set pass=0, and go to WR1.
  - WR1: write=1, addr=k, data_in=P(k), for k = 0..DEPTH-1, one location per cycle. Then RQ1 with k=0.
  - RQ1: read=1, addr=k; go to CK1.
  - CK1: strobes low; compare data_out with P(k). Then k+1 → RQ1, or after DEPTH-1 go to WR2 with k=0.
  - WR2, RQ2, CK2: identical to the pass-1 states, but with ~P(k). After CK2 at DEPTH-1 go to DONE.
  - DONE: done=1, busy=0, pass=(err_count==0). Go to IDLE.
- Mismatch handling:
  - err_count increments by 1. It cannot overflow: at most 2*DEPTH mismatches.
  - fail_addr/fail_exp/fail_got/fail_pass are captured only when err_count==0 before the increment.
- Output invariants:
  - read and write are never high together.
  - data_in=0 whenever write=0.
  - addr=0 in IDLE and DONE.
- start is ignored while busy. start held high gives back-to-back runs.
- Reset mid-test aborts the run with no partial result retained. The next start runs the full sequence from WR1.

## Timing
- Reset values: all outputs 0; state IDLE; k=0. Strobes drop asynchronously on rst_n low.
- Let edge 0 be the edge at which start=1 is sampled in IDLE.
  - busy is high from edge 0 through edge 6*DEPTH (192 cycles at defaults).
  - WR1 occupies cycles 1..DEPTH.
  - Pass 1 read/check occupies the next 2*DEPTH cycles.
  - Pass 2 write and read/check repeat the same structure.
  - done is high for the single cycle after edge 6*DEPTH; state returns to IDLE at the following edge.
- With start held high, runs start every 6*DEPTH+2 cycles (194 at defaults).
- All outputs are registered; no combinational path from data_out or start to any output.

## Test plan
- Fault-free memory, start pulsed one cycle: busy for 192 cycles, one done pulse, pass=1, err_count=0. Monitor shows 64 writes, 64 reads, never read&&write, and read of addr 31 followed by data_out=0xE0 in pass 2.
- Backdoor write mem[5]=0xAA after WR1 completes: err_count=1, fail_addr=5, fail_exp=0x05, fail_got=0xAA, fail_pass=0, pass=0.
- data_out bit0 forced to 0 for the whole run: err_count=32 (16 odd addresses in pass 1, 16 even in pass 2); first failure fail_addr=1, fail_exp=0x01, fail_got=0x00, fail_pass=0.
- data_out forced to 0x00: err_count=63 (addr 0 passes in pass 1); first failure fail_addr=1, fail_got=0x00; pass=0.
- rst_n pulled low at cycle 50 of a run: all outputs 0 immediately. A restart then completes with pass=1 after 192 busy cycles. start pulsed mid-run has no effect.
- start held high for 3 runs: done pulses exactly 194 cycles apart, and err_count/fail_* clear at each new run.
